sync_fifo: RTL and testbench

//   Single-clock first-in/first-out buffer for DBits-wide words. A producer pushes

---
 rtl/fifo_pkg.sv | 17 +
 rtl/fifo_ptr_ctrl.sv | 64 ++++++
 rtl/sync_fifo.sv | 67 ++++++
 tb/tb_sync_fifo.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_pkg
//  Description : Shared defaults and the pointer type for the synchronous FIFO.
//  Revision    : 1.0 - initial release
// ============================================================================
package fifo_pkg;

    // Default data width and address width (depth = 2**ABITS_DEF)
    localparam int DBITS_DEF = 8;
    localparam int ABITS_DEF = 4;

    // Pointer at the default depth: address bits plus one wrap bit
    typedef logic [ABITS_DEF:0] ptr_t;

endpackage : fifo_pkg
`default_nettype wire

// File: rtl/fifo_ptr_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_ptr_ctrl
//  Description : Read/write pointer registers, accept decisions and the
//                Empty/Full flag decode for the synchronous FIFO.
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_ptr_ctrl
    import fifo_pkg::*;
#(
    parameter int ABits = ABITS_DEF
) (
    input  logic             clk,
    input  logic             areset,
    input  logic             i_wr_en,
    input  logic             i_rd_en,
    output logic             o_wr_accept,
    output logic             o_rd_accept,
    output logic [ABits-1:0] o_wr_addr,
    output logic [ABits-1:0] o_rd_addr,
    output logic             o_empty,
    output logic             o_full
);

    localparam logic [ABits:0] c_ptr_one = {{ABits{1'b0}}, 1'b1};

    logic [ABits:0] r_wr_ptr;
    logic [ABits:0] r_rd_ptr;
    logic           w_empty;
    logic           w_full;
    logic           w_rd_accept;
    logic           w_wr_accept;

    // Flags come straight from the registered pointers; the MSB is the wrap bit
    always_comb begin
        w_empty     = (r_wr_ptr == r_rd_ptr);
        w_full      = (r_wr_ptr[ABits-1:0] == r_rd_ptr[ABits-1:0]) &&
                      (r_wr_ptr[ABits] != r_rd_ptr[ABits]);
        // A read frees a slot this cycle, so a write into a full FIFO is still
        // accepted alongside it; reads never bypass an empty FIFO.
        w_rd_accept = i_rd_en && !w_empty;
        w_wr_accept = i_wr_en && (!w_full || w_rd_accept);
    end

    // Pointer registers advance on each accepted access, cleared asynchronously
    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr_accept) r_wr_ptr <= r_wr_ptr + c_ptr_one;
            if (w_rd_accept) r_rd_ptr <= r_rd_ptr + c_ptr_one;
        end
    end

    assign o_wr_accept = w_wr_accept;
    assign o_rd_accept = w_rd_accept;
    assign o_wr_addr   = r_wr_ptr[ABits-1:0];
    assign o_rd_addr   = r_rd_ptr[ABits-1:0];
    assign o_empty     = w_empty;
    assign o_full      = w_full;

endmodule : fifo_ptr_ctrl
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : sync_fifo
//  Description : Single-clock FIFO with registered read data and combinational
//                Empty/Full flags. Storage array and output register live here;
//                pointer bookkeeping lives in fifo_ptr_ctrl.
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo
    import fifo_pkg::*;
#(
    parameter int DBits = DBITS_DEF,
    parameter int ABits = ABITS_DEF
) (
    input  logic             clk,
    input  logic             areset,
    input  logic [DBits-1:0] Input_Data_bits,
    input  logic             Write_Enable,
    input  logic             Read_Enable,
    output logic [DBits-1:0] Output_Data_bits,
    output logic             Empty,
    output logic             Full
);

    localparam int c_depth = 2 ** ABits;

    logic [DBits-1:0] r_mem [c_depth];
    logic [DBits-1:0] r_rd_data;
    logic             w_wr_accept;
    logic             w_rd_accept;
    logic [ABits-1:0] w_wr_addr;
    logic [ABits-1:0] w_rd_addr;
    logic             w_empty;
    logic             w_full;

    fifo_ptr_ctrl #(
        .ABits (ABits)
    ) u_ptr_ctrl (
        .clk         (clk),
        .areset      (areset),
        .i_wr_en     (Write_Enable),
        .i_rd_en     (Read_Enable),
        .o_wr_accept (w_wr_accept),
        .o_rd_accept (w_rd_accept),
        .o_wr_addr   (w_wr_addr),
        .o_rd_addr   (w_rd_addr),
        .o_empty     (w_empty),
        .o_full      (w_full)
    );

    // Storage array: written on accepted pushes only, never reset
    always_ff @(posedge clk) begin
        if (w_wr_accept) r_mem[w_wr_addr] <= Input_Data_bits;
    end

    // Read data register: loads on accepted pops, otherwise holds its value
    always_ff @(posedge clk or negedge areset) begin
        if (!areset)          r_rd_data <= '0;
        else if (w_rd_accept) r_rd_data <= r_mem[w_rd_addr];
    end

    assign Output_Data_bits = r_rd_data;
    assign Empty            = w_empty;
    assign Full             = w_full;

endmodule : sync_fifo
`default_nettype wire

// File: tb/tb_sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sync_fifo
//  Description : Self-checking bench for sync_fifo: vector table, directed
//                corner sequences and random traffic against a queue model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sync_fifo;

    localparam int c_dbits = 8;
    localparam int c_abits = 4;
    localparam int c_depth = 16;

    logic               clk = 1'b0;
    logic               areset = 1'b1;
    logic [c_dbits-1:0] Input_Data_bits = '0;
    logic               Write_Enable = 1'b0;
    logic               Read_Enable = 1'b0;
    logic [c_dbits-1:0] Output_Data_bits;
    logic               Empty;
    logic               Full;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: contents as a queue plus the last word popped
    logic [c_dbits-1:0] m_q [$];
    logic [c_dbits-1:0] m_out = '0;

    typedef struct {
        logic               we;
        logic               re;
        logic [c_dbits-1:0] din;
        logic [c_dbits-1:0] exp_out;
        logic               exp_empty;
        logic               exp_full;
    } vec_t;

    vec_t vecs [10];

    sync_fifo #(
        .DBits (c_dbits),
        .ABits (c_abits)
    ) dut (
        .clk              (clk),
        .areset           (areset),
        .Input_Data_bits  (Input_Data_bits),
        .Write_Enable     (Write_Enable),
        .Read_Enable      (Read_Enable),
        .Output_Data_bits (Output_Data_bits),
        .Empty            (Empty),
        .Full             (Full)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_model(input string name);
        chk({name, ".out"},   Output_Data_bits, m_out);
        chk({name, ".empty"}, Empty, (m_q.size() == 0));
        chk({name, ".full"},  Full,  (m_q.size() == c_depth));
    endtask

    // One clock: drive at the falling edge, update the model at the rising
    // edge, return 1 time unit after it so outputs can be sampled.
    task automatic step(input logic we, input logic re, input logic [c_dbits-1:0] din);
        bit rd_ok;
        bit wr_ok;
        @(negedge clk);
        Write_Enable    = we;
        Read_Enable     = re;
        Input_Data_bits = din;
        @(posedge clk);
        rd_ok = re && (m_q.size() != 0);
        wr_ok = we && ((m_q.size() < c_depth) || rd_ok);
        if (rd_ok) m_out = m_q.pop_front();
        if (wr_ok) m_q.push_back(din);
        #1;
    endtask

    // Assert reset between edges and confirm the outputs clear without a clock
    task automatic async_reset(input string name);
        @(negedge clk);
        #2 areset = 1'b0;
        #1;
        m_q.delete();
        m_out = '0;
        chk({name, ".rst_out"},   Output_Data_bits, 8'h00);
        chk({name, ".rst_empty"}, Empty, 1'b1);
        chk({name, ".rst_full"},  Full,  1'b0);
        Write_Enable = 1'b0;
        Read_Enable  = 1'b0;
        @(negedge clk);
        areset = 1'b1;
    endtask

    initial begin
        // Empty-FIFO read, single word round trip, held output, both-on-empty
        vecs[0] = '{1'b0, 1'b1, 8'h00, 8'h00, 1'b1, 1'b0};
        vecs[1] = '{1'b1, 1'b0, 8'hFF, 8'h00, 1'b0, 1'b0};
        vecs[2] = '{1'b0, 1'b1, 8'h00, 8'hFF, 1'b1, 1'b0};
        vecs[3] = '{1'b1, 1'b0, 8'h11, 8'hFF, 1'b0, 1'b0};
        vecs[4] = '{1'b1, 1'b0, 8'h22, 8'hFF, 1'b0, 1'b0};
        vecs[5] = '{1'b1, 1'b1, 8'h33, 8'h11, 1'b0, 1'b0};
        vecs[6] = '{1'b0, 1'b1, 8'h00, 8'h22, 1'b0, 1'b0};
        vecs[7] = '{1'b0, 1'b1, 8'h00, 8'h33, 1'b1, 1'b0};
        vecs[8] = '{1'b1, 1'b1, 8'h44, 8'h33, 1'b0, 1'b0};
        vecs[9] = '{1'b0, 1'b1, 8'h00, 8'h44, 1'b1, 1'b0};

        // Power-on asynchronous reset
        async_reset("init");

        for (int i = 0; i < 10; i++) begin
            step(vecs[i].we, vecs[i].re, vecs[i].din);
            chk($sformatf("vec%0d.out", i),   Output_Data_bits, vecs[i].exp_out);
            chk($sformatf("vec%0d.empty", i), Empty, vecs[i].exp_empty);
            chk($sformatf("vec%0d.full", i),  Full,  vecs[i].exp_full);
        end

        // Fill with A1, overflow write of AD is dropped, drain all A1
        for (int i = 0; i < c_depth; i++) begin
            step(1'b1, 1'b0, 8'hA1);
            chk($sformatf("fill%0d.full", i), Full, (i == c_depth - 1));
        end
        step(1'b1, 1'b0, 8'hAD);
        chk("ovf.full", Full, 1'b1);
        for (int i = 0; i < c_depth; i++) begin
            step(1'b0, 1'b1, 8'h00);
            chk($sformatf("drainA1_%0d.out", i), Output_Data_bits, 8'hA1);
            chk($sformatf("drainA1_%0d.empty", i), Empty, (i == c_depth - 1));
        end
        step(1'b0, 1'b1, 8'h00);
        chk("drainA1.extra_out", Output_Data_bits, 8'hA1);

        // Full FIFO with simultaneous read and write of 5A
        for (int i = 0; i < c_depth; i++) step(1'b1, 1'b0, 8'(i + 8'h10));
        step(1'b1, 1'b1, 8'h5A);
        chk("fullrw.full",  Full,  1'b1);
        chk("fullrw.empty", Empty, 1'b0);
        chk("fullrw.out",   Output_Data_bits, 8'h10);
        for (int i = 0; i < c_depth; i++) begin
            step(1'b0, 1'b1, 8'h00);
            chk($sformatf("drain5A_%0d.out", i), Output_Data_bits,
                (i == c_depth - 1) ? 8'h5A : 8'(i + 8'h11));
        end
        chk("drain5A.empty", Empty, 1'b1);

        // Reset in the middle of a write burst, then a read with no effect
        step(1'b1, 1'b0, 8'hC1);
        step(1'b1, 1'b0, 8'hC2);
        step(1'b0, 1'b1, 8'h00);
        step(1'b1, 1'b0, 8'hC3);
        chk("mid.out_pre", Output_Data_bits, 8'hC1);
        async_reset("mid");
        step(1'b0, 1'b1, 8'h00);
        chk("postrst.out",   Output_Data_bits, 8'h00);
        chk("postrst.empty", Empty, 1'b1);
        chk("postrst.full",  Full,  1'b0);

        // Random traffic with phases biased toward filling and draining
        for (int i = 0; i < 3000; i++) begin
            int wp;
            int rp;
            case ((i / 200) % 3)
                0:       begin wp = 80; rp = 30; end
                1:       begin wp = 30; rp = 80; end
                default: begin wp = 60; rp = 60; end
            endcase
            step(($urandom_range(0, 99) < wp), ($urandom_range(0, 99) < rp),
                 8'($urandom));
            chk_model($sformatf("rnd%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_sync_fifo
`default_nettype wire
